// File: rtl/and4_truth_table_checker.sv
// and4_truth_table_checker
//
// Exhaustive stimulus/response checker for a W-input AND gate. On start it
// drives every vector 0 .. 2^W-1 into the gate under test, one per clock,
// compares the gate output LAT clocks later against the AND of the vector,
// and reports the error count, the first failing vector and pass/fail.
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   start            begin a sweep (only honoured in IDLE or DONE)
//   vec_out          vector to the gate under test (bit W-1 = a ... bit 0 = d)
//   vec_valid        vec_out carries a vector under test
//   dut_s            gate under test output
//   busy             sweep or drain in progress
//   done             sweep complete, held until next accepted start or reset
//   pass             done with zero errors
//   err_count        mismatches in the current/last sweep (saturating)
//   first_fail       first mismatching vector
//   first_fail_valid first_fail holds a captured vector
module and4_truth_table_checker #(
    parameter int W   = 4,
    parameter int LAT = 1          // gate latency in clocks, 0..3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] vec_out,
    output logic         vec_valid,
    input  logic         dut_s,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [W:0]   err_count,
    output logic [W-1:0] first_fail,
    output logic         first_fail_valid
);

    localparam logic [W-1:0] LAST_VEC = '1;
    localparam logic [W:0]   ERR_MAX  = {1'b1, {W{1'b0}}};

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    state_t       state;
    logic [1:0]   drain_cnt;

    // Compare tap: expected bit, valid flag and vector index aligned with dut_s.
    logic         cmp_vld;
    logic         cmp_exp;
    logic [W-1:0] cmp_idx;

    generate
        if (LAT == 0) begin : g_comb
            // Combinational gate: compare against the vector on the wire now.
            assign cmp_vld = vec_valid;
            assign cmp_exp = &vec_out;
            assign cmp_idx = vec_out;
        end else begin : g_pipe
            logic [LAT:1]         vld_r;
            logic [LAT:1]         exp_r;
            logic [LAT:1][W-1:0]  idx_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_r <= '0;
                    exp_r <= '0;
                    idx_r <= '0;
                end else begin
                    vld_r[1] <= vec_valid;
                    exp_r[1] <= &vec_out;
                    idx_r[1] <= vec_out;
                    for (int j = 2; j <= LAT; j++) begin
                        vld_r[j] <= vld_r[j-1];
                        exp_r[j] <= exp_r[j-1];
                        idx_r[j] <= idx_r[j-1];
                    end
                end
            end

            assign cmp_vld = vld_r[LAT];
            assign cmp_exp = exp_r[LAT];
            assign cmp_idx = idx_r[LAT];
        end
    endgenerate

    // Case inequality so an X/Z from the gate under test counts as a mismatch.
    logic       mism;
    logic [W:0] err_next;

    always_comb begin
        mism     = cmp_vld && (dut_s !== cmp_exp);
        err_next = err_count;
        if (mism && (err_count != ERR_MAX))
            err_next = err_count + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            drain_cnt        <= '0;
            vec_out          <= '0;
            vec_valid        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            err_count <= err_next;
            if (mism && !first_fail_valid) begin
                first_fail       <= cmp_idx;
                first_fail_valid <= 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Later assignments override any compare update above;
                        // the pipeline is empty here so nothing is lost.
                        state            <= DRIVE;
                        vec_out          <= '0;
                        vec_valid        <= 1'b1;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (vec_out == LAST_VEC) begin
                        vec_out   <= '0;
                        vec_valid <= 1'b0;
                        if (LAT > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            // Last compare lands on this same edge.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end
                    end else begin
                        vec_out <= vec_out + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(LAT - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
